// File: rtl/music_pkg.sv
// Shared types and defaults for the buzzer playlist sequencer.
package music_pkg;

  localparam int SONG_W        = 2;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_GAP_W     = 28;
  localparam int DEF_BLANK_CYC = 4;

  typedef logic [SONG_W-1:0] song_t;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    BLANK,
    PLAY,
    GAP
  } state_e;

endpackage

// File: rtl/playlist_fifo.sv
// Synchronous song-select FIFO with flush; DEPTH must be a power of two so pointers wrap naturally.
module playlist_fifo
  import music_pkg::*;
#(
  parameter int  DEPTH = DEF_DEPTH,
  parameter int  W     = SONG_W,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Fullness is judged before any same-cycle pop, so a push to a full FIFO is always dropped.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; count/pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/music_playlist_ctrl.sv
// Playlist sequencer: queues song selects, launches each, masks stale finish, inserts a silent gap.
// Build option MUSIC_PLAYLIST_IRQ_EN adds a sticky "playlist drained" irq with irq_clr.
module music_playlist_ctrl
  import music_pkg::*;
#(
  parameter int  DEPTH     = DEF_DEPTH,
  parameter int  GAP_W     = DEF_GAP_W,
  parameter int  BLANK_CYC = DEF_BLANK_CYC,
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  input  logic [SONG_W-1:0] cmd_select,
  output logic              cmd_ready,
  input  logic              flush,
  input  logic              play_en,
  input  logic [GAP_W-1:0]  gap_cycles,
  output logic [SONG_W-1:0] music_select,
  output logic              music_start,
  input  logic              music_finish,
  output logic              busy,
  output logic [CW-1:0]     fifo_count,
`ifdef MUSIC_PLAYLIST_IRQ_EN
  output logic              irq,
  input  logic              irq_clr,
`endif
  output logic              song_done
);

  localparam int            BW         = $clog2(BLANK_CYC) + 1;
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYC - 1);

  state_e           state;
  state_e           state_nx;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  song_t            fifo_head;
  logic [BW-1:0]    blank_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             gap_done;

  playlist_fifo #(
    .DEPTH (DEPTH),
    .W     (SONG_W)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (cmd_valid),
    .din   (cmd_select),
    .pop   (fifo_pop),
    .flush (flush),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign cmd_ready   = !fifo_full;
  assign gap_done    = (state == GAP) && (gap_cnt == '0);
  assign music_start = (state == LAUNCH);
  assign song_done   = (state == PLAY) && music_finish;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    fifo_pop = 1'b0;
    unique case (state)
      IDLE: begin
        if (play_en && !fifo_empty && !flush) begin
          fifo_pop = 1'b1;
          state_nx = LAUNCH;
        end
      end
      LAUNCH: state_nx = BLANK;
      BLANK:  if (blank_cnt == BLANK_LAST) state_nx = PLAY;
      PLAY:   if (music_finish) state_nx = GAP;
      GAP:    if (gap_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The select is captured at pop so it is already stable during the start pulse.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      music_select <= '0;
      blank_cnt    <= '0;
      gap_cnt      <= '0;
    end else begin
      if (fifo_pop) music_select <= fifo_head;
      blank_cnt <= (state == BLANK) ? blank_cnt + BW'(1) : '0;
      if (song_done)
        gap_cnt <= gap_cycles;
      else if ((state == GAP) && (gap_cnt != '0))
        gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end

`ifdef MUSIC_PLAYLIST_IRQ_EN
  // Set on the GAP->IDLE step with nothing left to play; set wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rstn)                     irq <= 1'b0;
    else if (gap_done && fifo_empty) irq <= 1'b1;
    else if (irq_clr)              irq <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_music_playlist_ctrl.sv
// Randomized scoreboard bench for music_playlist_ctrl; irq checks follow MUSIC_PLAYLIST_IRQ_EN.
module tb_music_playlist_ctrl;

  localparam int DEPTH     = 4;
  localparam int GAP_W     = 28;
  localparam int BLANK_CYC = 4;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rstn;
  logic             cmd_valid;
  logic [1:0]       cmd_select;
  logic             cmd_ready;
  logic             flush;
  logic             play_en;
  logic [GAP_W-1:0] gap_cycles;
  logic [1:0]       music_select;
  logic             music_start;
  logic             music_finish;
  logic             busy;
  logic [CW-1:0]    fifo_count;
  logic             song_done;
`ifdef MUSIC_PLAYLIST_IRQ_EN
  logic             irq;
  logic             irq_clr;
`endif

  music_playlist_ctrl #(
    .DEPTH     (DEPTH),
    .GAP_W     (GAP_W),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .cmd_valid    (cmd_valid),
    .cmd_select   (cmd_select),
    .cmd_ready    (cmd_ready),
    .flush        (flush),
    .play_en      (play_en),
    .gap_cycles   (gap_cycles),
    .music_select (music_select),
    .music_start  (music_start),
    .music_finish (music_finish),
    .busy         (busy),
    .fifo_count   (fifo_count),
`ifdef MUSIC_PLAYLIST_IRQ_EN
    .irq          (irq),
    .irq_clr      (irq_clr),
`endif
    .song_done    (song_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model: timestamps + song queue ----------------
  typedef struct {
    logic [1:0] sel;
    int         at;
  } start_t;

  logic [1:0] m_q[$];
  start_t     start_q[$];
  int         done_q[$];
  bit         m_song_on   = 0;
  bit         m_after_song = 0;
  int         m_start_cyc = 0;
  int         m_play_from = 0;
  int         m_idle_from = 0;
  logic [1:0] m_sel       = 2'd0;

  int         e_count;
  bit         e_ready;
  bit         e_busy;
  logic [1:0] e_sel;
`ifdef MUSIC_PLAYLIST_IRQ_EN
  bit         m_irq = 0;
  bit         e_irq;
  bit         st_irq_clr = 0;
`endif

  bit               st_rstn    = 0;
  bit               st_play_en = 0;
  logic [GAP_W-1:0] st_gap     = '0;
  int               fin_mode   = 0;   // 0: pulse fin_delay after start, 1: held high, 2: random
  int               fin_delay  = 20;
  bit               chk_en     = 0;
  int               n_start    = 0;
  int               n_done     = 0;

  task automatic model_step(input bit v, input logic [1:0] s, input bit fl, input bit fin);
    int     c;
    int     size0;
    bit     idle_now;
    start_t st;
`ifdef MUSIC_PLAYLIST_IRQ_EN
    bit     irq_set;
`endif
    c        = cyc;
    size0    = m_q.size();
    idle_now = !m_song_on && (c >= m_idle_from);
    e_count  = size0;
    e_ready  = (size0 < DEPTH);
    e_busy   = !idle_now;
    e_sel    = m_sel;
`ifdef MUSIC_PLAYLIST_IRQ_EN
    e_irq    = m_irq;
`endif
    if (!st_rstn) begin
      m_q.delete();
      m_song_on    = 0;
      m_after_song = 0;
      m_idle_from  = c + 1;
      m_sel        = 2'd0;
`ifdef MUSIC_PLAYLIST_IRQ_EN
      m_irq        = 0;
`endif
      return;
    end
`ifdef MUSIC_PLAYLIST_IRQ_EN
    irq_set = m_after_song && !m_song_on && (c == m_idle_from - 1) && (size0 == 0);
`endif
    if (m_song_on && (c >= m_play_from) && fin) begin
      done_q.push_back(c);
      m_song_on    = 0;
      m_after_song = 1;
      m_idle_from  = c + int'(st_gap) + 2;   // gap+1 silent cycles, then IDLE
    end
    if (idle_now && st_play_en && (size0 != 0) && !fl) begin
      m_sel  = m_q.pop_front();
      st.sel = m_sel;
      st.at  = c + 1;
      start_q.push_back(st);
      m_song_on   = 1;
      m_start_cyc = c + 1;
      m_play_from = c + 2 + BLANK_CYC;
    end
    if (fl) m_q.delete();
    else if (v && (size0 < DEPTH)) m_q.push_back(s);
`ifdef MUSIC_PLAYLIST_IRQ_EN
    if (irq_set) m_irq = 1;
    else if (st_irq_clr) m_irq = 0;
`endif
  endtask

  task automatic run_cycle(input bit v, input logic [1:0] s, input bit fl);
    bit fin;
    @(posedge clk);
    #1;
    case (fin_mode)
      0:       fin = m_song_on && (cyc == m_start_cyc + fin_delay);
      1:       fin = 1'b1;
      default: fin = ($urandom_range(0, 3) == 0);
    endcase
    if (!st_rstn) fin = 1'b0;
    cmd_valid    = v;
    cmd_select   = s;
    flush        = fl;
    play_en      = st_play_en;
    gap_cycles   = st_gap;
    music_finish = fin;
    rstn         = st_rstn;
`ifdef MUSIC_PLAYLIST_IRQ_EN
    irq_clr      = st_irq_clr;
`endif
    model_step(v, s, fl, fin);
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 2'd0, 1'b0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    start_t st;
    int     d;
    if (chk_en) begin
      check("fifo_count", fifo_count, e_count);
      check("cmd_ready", cmd_ready, e_ready);
      check("busy", busy, e_busy);
      check("music_select", music_select, e_sel);
`ifdef MUSIC_PLAYLIST_IRQ_EN
      check("irq", irq, e_irq);
`endif
      if (music_start === 1'b1) begin
        n_start++;
        if (start_q.size() == 0) check("music_start", music_start, 0);
        else begin
          st = start_q.pop_front();
          check("start_cycle", cyc, st.at);
          check("start_select", music_select, st.sel);
        end
      end else if (start_q.size() != 0 && start_q[0].at <= cyc) begin
        check("music_start", music_start, 1);
        void'(start_q.pop_front());
      end
      if (song_done === 1'b1) begin
        n_done++;
        if (done_q.size() == 0) check("song_done", song_done, 0);
        else begin
          d = done_q.pop_front();
          check("done_cycle", cyc, d);
        end
      end else if (done_q.size() != 0 && done_q[0] <= cyc) begin
        check("song_done", song_done, 1);
        void'(done_q.pop_front());
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int s0;
    int d0;
    rstn = 1'b0; cmd_valid = 1'b0; cmd_select = 2'd0; flush = 1'b0;
    play_en = 1'b0; gap_cycles = '0; music_finish = 1'b0;
`ifdef MUSIC_PLAYLIST_IRQ_EN
    irq_clr = 1'b0;
`endif
    run_idle(2);
    chk_en  = 1;
    run_idle(1);
    st_rstn = 1;
    run_idle(2);

    // Three songs 2,1,3 with gap 10 and finish 20 cycles after each start.
    st_play_en = 1; st_gap = 10; fin_mode = 0; fin_delay = 20;
    s0 = n_start; d0 = n_done;
    run_cycle(1, 2'd2, 0);
    run_cycle(1, 2'd1, 0);
    run_cycle(1, 2'd3, 0);
    run_idle(150);
    check("three_starts", n_start - s0, 3);
    check("three_dones", n_done - d0, 3);

    // Stale finish held high: done only after the blank window.
    st_gap = 2; fin_mode = 1;
    d0 = n_done;
    run_cycle(1, 2'd1, 0);
    run_idle(30);
    fin_mode = 0;
    run_idle(5);
    check("held_finish_done", n_done - d0, 1);

    // Fill with play_en low: fifth push dropped.
    st_play_en = 0; fin_delay = 8; st_gap = 1;
    for (int i = 0; i < 5; i++) run_cycle(1, 2'(i + 1), 0);
    run_idle(1);
    check("full_count", fifo_count, 4);
    check("full_ready", cmd_ready, 0);
    s0 = n_start;
    st_play_en = 1;
    run_idle(120);
    check("drain_starts", n_start - s0, 4);
    check("drained_count", fifo_count, 0);

    // Flush during PLAY with three queued.
    fin_delay = 20; st_gap = 3;
    s0 = n_start; d0 = n_done;
    for (int i = 0; i < 4; i++) run_cycle(1, 2'(3 - i), 0);
    for (int i = 0; i < 40 && !(m_song_on && cyc >= m_play_from); i++) run_idle(1);
    check("pre_flush_count", fifo_count, 3);
    run_cycle(0, 2'd0, 1);
    run_idle(1);
    check("post_flush_count", fifo_count, 0);
    run_idle(60);
    check("flush_busy", busy, 0);
    check("flush_starts", n_start - s0, 1);
    check("flush_dones", n_done - d0, 1);

    // Reset mid-GAP with two queued.
    st_gap = 20; fin_delay = 6;
    for (int i = 0; i < 3; i++) run_cycle(1, 2'(i), 0);
    for (int i = 0; i < 40 && !(m_after_song && !m_song_on && cyc < m_idle_from - 2); i++) run_idle(1);
    check("pre_reset_count", fifo_count, 2);
    st_rstn = 0;
    run_idle(1);
    st_rstn = 1;
    run_idle(1);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_start", music_start, 0);
`ifdef MUSIC_PLAYLIST_IRQ_EN
    check("rst_irq", irq, 0);
`endif
    run_idle(5);

`ifdef MUSIC_PLAYLIST_IRQ_EN
    // irq rises on drain; a clear on the same cycle as the set loses.
    st_gap = 3;
    st_irq_clr = 1; run_idle(1); st_irq_clr = 0; run_idle(1);
    check("irq_cleared", irq, 0);
    run_cycle(1, 2'd2, 0);
    for (int i = 0; i < 40 && !(m_after_song && !m_song_on && cyc + 1 == m_idle_from - 1); i++) run_idle(1);
    st_irq_clr = 1; run_idle(1); st_irq_clr = 0;
    run_idle(1);
    check("irq_set_wins", irq, 1);
    st_irq_clr = 1; run_idle(1); st_irq_clr = 0;
    run_idle(1);
    check("irq_clr", irq, 0);
`endif

    // Randomized traffic.
    fin_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) st_play_en = !st_play_en;
      st_gap  = GAP_W'($urandom_range(0, 4));
      st_rstn = ($urandom_range(0, 299) != 0);
`ifdef MUSIC_PLAYLIST_IRQ_EN
      st_irq_clr = ($urandom_range(0, 7) == 0);
`endif
      run_cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ($urandom_range(0, 49) == 0));
    end
    st_rstn = 1; st_play_en = 1;
`ifdef MUSIC_PLAYLIST_IRQ_EN
    st_irq_clr = 0;
`endif
    run_idle(200);
    check("pending_starts", start_q.size(), 0);
    check("pending_dones", done_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/music_playlist_ctrl.md
Name: music_playlist_ctrl

Overview:
- Upstream sequencer for the buzzer music player.
- Accepts song-select commands from the CPU-side register logic into a small FIFO.
- Launches each song with a select/start pair, waits for the player's finish flag, then inserts a programmable silent gap before the next song.
- Sits between the APB/AHB buzzer register block and the music player's music_select/music_start/music_finish ports.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- GAP_W, 28, width of gap counter and gap_cycles input.
- BLANK_CYC, 4, cycles after start during which music_finish is ignored; must be >=1.

Ports:
- clk  in  1  system clock.
- rstn  in  1  synchronous active-low reset.
- cmd_valid  in  1  push request.
- cmd_select  in  2  song index to queue.
- cmd_ready  out  1  FIFO can accept; equals !fifo_full.
- flush  in  1  one-cycle pulse; empties FIFO.
- play_en  in  1  level; 0 = hold off launching new songs.
- gap_cycles  in  GAP_W  silent cycles between songs; sampled on entry to GAP.
- music_select  out  2  select to player; held stable after launch.
- music_start  out  1  one-cycle launch pulse.
- music_finish  in  1  player finished (level).
- busy  out  1  state != IDLE.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.
- song_done  out  1  one-cycle pulse when a song's finish is accepted.

Behaviour:
- Reset (rstn=0 at posedge): state=IDLE, FIFO empty, fifo_count=0, music_select=0, music_start=0, song_done=0, busy=0, all counters 0. Reset overrides everything, including mid-song and mid-gap.
- Push: cmd_valid && cmd_ready writes cmd_select at wr_ptr; count+1 next cycle.
- A push while full is ignored, even if a pop occurs in the same cycle.
- Pointers wrap modulo DEPTH.
- Pop occurs only in the IDLE->LAUNCH transition.
- A simultaneous push and pop leaves the count unchanged and is legal.
- flush: pointers and count go to 0 next cycle; a push in the same cycle is discarded; flush has priority over pop.
- flush does not abort the current song; the FSM runs to completion.
- IDLE: if play_en && count!=0 && !flush, pop head into music_select and go to LAUNCH.
- LAUNCH: music_start=1 for exactly this cycle; music_select is already valid, i.e. it changes together with or before start. Go to BLANK.
- BLANK: count BLANK_CYC cycles with music_finish ignored, which masks a stale finish from the previous song. Go to PLAY.
- PLAY: wait for music_finish==1. On that cycle, song_done=1 for one cycle, load the gap counter with gap_cycles, and go to GAP.
- GAP: decrement each cycle; at 0 go to IDLE.
- gap_cycles=0 means GAP lasts exactly 1 cycle.
- Latency: push into an idle empty FIFO with play_en=1 gives the pop at +1 cycle and music_start at +2.
- play_en=0 only blocks the IDLE->LAUNCH transition; it never interrupts PLAY or GAP.
- music_select holds its last value in all states; it is never cleared except by reset.
- busy=1 in LAUNCH, BLANK, PLAY and GAP.

Optional Feature:
- Macro: MUSIC_PLAYLIST_IRQ_EN.
- Defined: adds ports irq out 1 and irq_clr in 1.
  - irq is a sticky flag, set on the cycle the FSM returns to IDLE with the FIFO empty (playlist drained).
  - irq_clr clears it next cycle; set wins over a simultaneous clear.
  - Reset value 0.
- Undefined: no irq/irq_clr ports; behaviour otherwise identical.

Decomposition:
- Shared package music_pkg holds:
  - state enum (IDLE, LAUNCH, BLANK, PLAY, GAP);
  - SONG_W=2;
  - default GAP and BLANK constants.
- One sub-module: playlist_fifo (synchronous FIFO).
  - Parameters: DEPTH, width SONG_W.
  - Ports: push/pop/flush, full/empty/count.
  - Same clk/rstn convention.

Test Plan:
- Push selects 2,1,3 with play_en=1, gap_cycles=10, finish pulsed 20 cycles after each start -> three music_start pulses with music_select 2,1,3 in order; 3 song_done pulses; 11-cycle spacing from each finish to the next pop.
- Hold music_finish=1 continuously, push one song -> no song_done before BLANK_CYC cycles after start; song_done on the first PLAY cycle.
- Push 5 entries with DEPTH=4 and play_en=0 -> cmd_ready=0 after 4; 5th push dropped; fifo_count=4.
- Then set play_en=1 -> entries popped in order; count decrements on each LAUNCH.
- Assert flush during PLAY with 3 queued -> count=0 next cycle; current song still completes with song_done; FSM then returns to IDLE and does not launch again.
- Assert rstn=0 during GAP with 2 queued -> next cycle: state IDLE, count 0, music_start 0, busy 0; irq=0 (with MUSIC_PLAYLIST_IRQ_EN).
- With MUSIC_PLAYLIST_IRQ_EN, play one song to completion -> irq rises on return to IDLE; irq_clr on the same cycle as a new set -> irq stays 1.
